w2_update: RTL and testbench

Weight-update stage for the second layer. It sits directly downstream of the dw2 gradient store and consumes its nine 16-bit gradients `dw2_0`..`dw2_8`. On `start` it snapshots all nine gradients and then sequentially applies `w2[i] <= sat(w2[i] - (dw2[i] >>> lr_shift))`, one weight per cycle. It holds the nine layer-2 weights that feed the forward pass, and exposes a preload port for initial weights.

---
 rtl/dqn_pkg.sv | 10 +
 rtl/sat_sub.sv | 19 +
 rtl/w2_update.sv | 121 ++++++++++++
 tb/tb_w2_update.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dqn_pkg.sv
// Shared types and constants for the DQN training datapath.
package dqn_pkg;
  localparam int WIDTH = 16;
  localparam int N_W   = 9;

  typedef enum logic [1:0] {IDLE, UPD, DONE} w2u_state_t;

  localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
endpackage

// File: rtl/sat_sub.sv
// Saturating signed subtract y = sat(a - b), computed one bit wider.
module sat_sub #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] y
);
  logic signed [WIDTH:0] diff;

  assign diff = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  // Overflow shows up as the two top bits disagreeing; the top bit gives direction.
  always_comb begin
    y = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1])
      y = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
endmodule

// File: rtl/w2_update.sv
// Layer-2 weight updater: snapshot nine gradients, then apply one SGD step per cycle.
module w2_update
  import dqn_pkg::*;
#(
  parameter int WIDTH = dqn_pkg::WIDTH,
  parameter int N_W   = dqn_pkg::N_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       lr_shift,
  input  logic [WIDTH-1:0] dw2_0,
  input  logic [WIDTH-1:0] dw2_1,
  input  logic [WIDTH-1:0] dw2_2,
  input  logic [WIDTH-1:0] dw2_3,
  input  logic [WIDTH-1:0] dw2_4,
  input  logic [WIDTH-1:0] dw2_5,
  input  logic [WIDTH-1:0] dw2_6,
  input  logic [WIDTH-1:0] dw2_7,
  input  logic [WIDTH-1:0] dw2_8,
  input  logic             load_en,
  input  logic [3:0]       load_idx,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] w2_0,
  output logic [WIDTH-1:0] w2_1,
  output logic [WIDTH-1:0] w2_2,
  output logic [WIDTH-1:0] w2_3,
  output logic [WIDTH-1:0] w2_4,
  output logic [WIDTH-1:0] w2_5,
  output logic [WIDTH-1:0] w2_6,
  output logic [WIDTH-1:0] w2_7,
  output logic [WIDTH-1:0] w2_8,
  output logic             busy,
  output logic             done
);
  logic signed [WIDTH-1:0] w2    [N_W];
  logic signed [WIDTH-1:0] snap  [N_W];
  logic        [WIDTH-1:0] dw_in [N_W];
  logic [3:0]              sh;
  logic [3:0]              idx;
  w2u_state_t              state;

  logic signed [WIDTH-1:0] cur_w, cur_g, upd_w;

  assign dw_in[0] = dw2_0;
  assign dw_in[1] = dw2_1;
  assign dw_in[2] = dw2_2;
  assign dw_in[3] = dw2_3;
  assign dw_in[4] = dw2_4;
  assign dw_in[5] = dw2_5;
  assign dw_in[6] = dw2_6;
  assign dw_in[7] = dw2_7;
  assign dw_in[8] = dw2_8;

  assign w2_0 = w2[0];
  assign w2_1 = w2[1];
  assign w2_2 = w2[2];
  assign w2_3 = w2[3];
  assign w2_4 = w2[4];
  assign w2_5 = w2[5];
  assign w2_6 = w2[6];
  assign w2_7 = w2[7];
  assign w2_8 = w2[8];

  // Single shared datapath: only the weight selected by idx is touched each cycle.
  assign cur_w = w2[idx];
  assign cur_g = snap[idx] >>> sh;

  sat_sub #(.WIDTH(WIDTH)) u_sat (
    .a (cur_w),
    .b (cur_g),
    .y (upd_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_W; i++) begin
        w2[i]   <= '0;
        snap[i] <= '0;
      end
      sh    <= '0;
      idx   <= '0;
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_W; i++) snap[i] <= dw_in[i];
            sh    <= lr_shift;
            idx   <= '0;
            state <= UPD;
            busy  <= 1'b1;
          end else if (load_en && load_idx < 4'(N_W)) begin
            w2[load_idx] <= load_data;
          end
        end
        UPD: begin
          w2[idx] <= upd_w;
          if (idx == 4'(N_W - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            idx <= idx + 4'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_w2_update.sv
// Self-checking bench for w2_update: behavioural model plus directed literal checks.
module tb_w2_update;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, load_en;
  logic [3:0]  lr_shift, load_idx;
  logic [15:0] load_data;
  logic [15:0] dw [9];
  logic [15:0] wo [9];
  logic        busy, done;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  w2_update dut (
    .clk(clk), .rst(rst), .start(start), .lr_shift(lr_shift),
    .dw2_0(dw[0]), .dw2_1(dw[1]), .dw2_2(dw[2]), .dw2_3(dw[3]), .dw2_4(dw[4]),
    .dw2_5(dw[5]), .dw2_6(dw[6]), .dw2_7(dw[7]), .dw2_8(dw[8]),
    .load_en(load_en), .load_idx(load_idx), .load_data(load_data),
    .w2_0(wo[0]), .w2_1(wo[1]), .w2_2(wo[2]), .w2_3(wo[3]), .w2_4(wo[4]),
    .w2_5(wo[5]), .w2_6(wo[6]), .w2_7(wo[7]), .w2_8(wo[8]),
    .busy(busy), .done(done)
  );

  // Model: mpos = 0 idle, 1..9 = about to update weight mpos-1, 10 = done cycle.
  int mw [9];
  int msnap [9];
  int msh, mpos;

  function automatic int sat16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) begin mw[i] = 0; msnap[i] = 0; end
      msh = 0; mpos = 0;
    end else if (mpos == 0) begin
      if (start) begin
        for (int i = 0; i < 9; i++) msnap[i] = int'($signed(dw[i]));
        msh = int'(lr_shift);
        mpos = 1;
      end else if (load_en && load_idx < 9) begin
        mw[load_idx] = int'($signed(load_data));
      end
    end else if (mpos <= 9) begin
      mw[mpos-1] = sat16(mw[mpos-1] - (msnap[mpos-1] >>> msh));
      mpos = mpos + 1;
    end else begin
      mpos = 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) chk($sformatf("model_w2_%0d", i), int'($signed(wo[i])), mw[i]);
      chk("model_busy", int'(busy), int'(mpos >= 1 && mpos <= 9));
      chk("model_done", int'(done), int'(mpos == 10));
    end
  end

  task automatic load(input int i, input int d);
    load_en = 1'b1; load_idx = 4'(i); load_data = 16'(d);
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  // Launch a pass and wait for done; returns edges after E0 until done is seen.
  task automatic run_pass(input int lr, output int lat);
    lr_shift = 4'(lr); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, dcnt;
    rst = 1'b0; start = 1'b0; load_en = 1'b0; lr_shift = '0; load_idx = '0; load_data = '0;
    for (int i = 0; i < 9; i++) dw[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_w2_0", int'(wo[0]), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic pass
    for (int i = 0; i < 9; i++) load(i, 100 * (i + 1));
    for (int i = 0; i < 9; i++) dw[i] = 16'(16 * (i + 1));
    lr_shift = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    chk("done_latency", lat, 9);
    @(posedge clk); #1;
    chk("done_width", int'(done), 0);
    for (int i = 0; i < 9; i++) chk($sformatf("basic_w2_%0d", i), int'($signed(wo[i])), 96 * (i + 1));

    // Saturation both ways
    load(3, 32000); load(4, -32000);
    for (int i = 0; i < 9; i++) dw[i] = '0;
    dw[3] = 16'(-2000); dw[4] = 16'(2000);
    run_pass(0, lat);
    chk("sat_hi", int'($signed(wo[3])), 32767);
    chk("sat_lo", int'($signed(wo[4])), -32768);

    // Arithmetic shift of a negative gradient
    for (int i = 0; i < 9; i++) dw[i] = '0;
    load(0, 0); dw[0] = 16'hFFFF;
    run_pass(4, lat);
    chk("neg_shift", int'($signed(wo[0])), 1);

    // Snapshot integrity, ignored restart, load during UPD
    for (int i = 0; i < 9; i++) dw[i] = 16'($urandom);
    lr_shift = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 9; i++) dw[i] = 16'h7FFF;
    load_en = 1'b1; load_idx = 4'd2; load_data = 16'd1234;
    @(posedge clk); @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("single_done", dcnt, 1);

    // start + load on the same cycle, then out-of-range load index
    load_en = 1'b1; load_idx = 4'd0; load_data = 16'd555; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    load(12, 16'h1111);
    load(15, 16'h2222);

    // Async reset mid-pass
    for (int i = 0; i < 9; i++) load(i, 1000 + i);
    lr_shift = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) chk($sformatf("async_w2_%0d", i), int'(wo[i]), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    load(5, 700); dw[5] = 16'd64;
    run_pass(3, lat);
    chk("post_reset_latency", lat, 9);
    chk("post_reset_w2_5", int'($signed(wo[5])), 692);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start     = ($urandom_range(0, 19) == 0);
      load_en   = $urandom_range(0, 1) == 1;
      load_idx  = 4'($urandom_range(0, 15));
      load_data = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 16'h7FF0 : 16'h8010)
                                              : 16'($urandom);
      lr_shift  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 9; i++) dw[i] = 16'($urandom);
    end
    start = 1'b0; load_en = 1'b0;
    repeat (15) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
